// File: rtl/intr_controller_pkg.sv
// Shared constants for the memory-mapped interrupt controller: register map,
// FSM encoding and CAUSE layout.
package intr_controller_pkg;

    localparam logic [3:0] INTC_MASK  = 4'h0;
    localparam logic [3:0] INTC_PEND  = 4'h4;
    localparam logic [3:0] INTC_CAUSE = 4'h8;
    localparam logic [3:0] INTC_EOI   = 4'hC;

    localparam int CAUSE_VALID_BIT = 31;
    localparam int NSRC_MAX        = 16;

    typedef enum logic [1:0] {
        IC_IDLE    = 2'd0,
        IC_REQ     = 2'd1,
        IC_SERVICE = 2'd2
    } ic_state_e;

    function automatic logic [NSRC_MAX-1:0] id_onehot(input logic [3:0] id);
        return 16'h0001 << id;
    endfunction

endpackage

// File: rtl/intr_controller_if.sv
// Peripheral request lines, CPU handshake and data-bus slave port of the
// interrupt controller.
interface intr_controller_if #(
    parameter int NSRC = 4
);
    logic [NSRC-1:0] Irq;
    logic            Inta;
    logic            Intr;
    logic            Sel;
    logic [3:0]      Addr;
    logic [31:0]     Wdata;
    logic            Wmem;
    logic [31:0]     Rdata;

    modport master (
        output Irq, Inta, Sel, Addr, Wdata, Wmem,
        input  Intr, Rdata
    );

    modport slave (
        input  Irq, Inta, Sel, Addr, Wdata, Wmem,
        output Intr, Rdata
    );
endinterface

// File: rtl/intr_controller_prio.sv
// Lowest-index-wins priority encoder over the masked pending vector.
module intr_prio_enc #(
    parameter int NSRC = 4
) (
    input  logic [NSRC-1:0] req,
    output logic [3:0]      id,
    output logic            found
);

    // Scanning downward lets the lowest set index overwrite any higher one.
    always_comb begin
        id    = '0;
        found = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                id    = 4'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intr_controller.sv
// Interrupt controller: edge capture, software mask, Intr/Inta handshake with
// CAUSE latching, and end-of-interrupt gating.
module intr_controller
    import intr_controller_pkg::*;
#(
    parameter int NSRC = 4
) (
    input  logic              Clk,
    input  logic              Clrn,
    intr_controller_if.slave  bus
);

    logic [NSRC-1:0] irq_d_q, irq_d_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic            cause_vld_q, cause_vld_d;
    logic [3:0]      cause_id_q, cause_id_d;
    ic_state_e       state_q, state_d;
    logic            intr_q, intr_d;

    logic [NSRC-1:0]     rise;
    logic [NSRC-1:0]     masked_pend;
    logic [NSRC-1:0]     ack_clr;
    logic [NSRC_MAX-1:0] win_onehot;
    logic [3:0]          win_id;
    logic                win_found;
    logic [3:0]          reg_off;
    logic                wr_en;
    logic                mask_wr;
    logic                eoi_wr;
    logic [31:0]         rdata;
    logic                unused_bits;

    assign reg_off     = {bus.Addr[3:2], 2'b00};
    assign wr_en       = bus.Sel & bus.Wmem;
    assign mask_wr     = wr_en && (reg_off == INTC_MASK);
    assign eoi_wr      = wr_en && (reg_off == INTC_EOI);
    assign rise        = bus.Irq & ~irq_d_q;
    assign masked_pend = pend_q & mask_q;
    assign win_onehot  = id_onehot(win_id);
    assign unused_bits = ^{bus.Addr[1:0], bus.Wdata, win_onehot};

    intr_prio_enc #(.NSRC(NSRC)) u_prio (
        .req   (masked_pend),
        .id    (win_id),
        .found (win_found)
    );

    always_comb begin
        state_d     = state_q;
        cause_vld_d = cause_vld_q;
        cause_id_d  = cause_id_q;
        ack_clr     = '0;
        case (state_q)
            IC_IDLE: begin
                if (win_found) state_d = IC_REQ;
            end
            IC_REQ: begin
                if (bus.Inta) begin
                    if (win_found) begin
                        state_d     = IC_SERVICE;
                        cause_vld_d = 1'b1;
                        cause_id_d  = win_id;
                        ack_clr     = win_onehot[NSRC-1:0];
                    end else begin
                        // Acknowledge with nothing left to serve: spurious.
                        state_d     = IC_IDLE;
                        cause_vld_d = 1'b0;
                        cause_id_d  = '0;
                    end
                end else if (!win_found) begin
                    state_d = IC_IDLE;
                end
            end
            IC_SERVICE: begin
                if (eoi_wr) begin
                    state_d     = IC_IDLE;
                    cause_vld_d = 1'b0;
                end
            end
            default: state_d = IC_IDLE;
        endcase
    end

    always_comb begin
        irq_d_d = bus.Irq;
        // A fresh edge on the source being acknowledged keeps it pending.
        pend_d  = (pend_q & ~ack_clr) | rise;
        mask_d  = mask_wr ? bus.Wdata[NSRC-1:0] : mask_q;
        intr_d  = (state_d == IC_REQ);
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            irq_d_q     <= '0;
            mask_q      <= '0;
            pend_q      <= '0;
            cause_vld_q <= 1'b0;
            cause_id_q  <= '0;
            state_q     <= IC_IDLE;
            intr_q      <= 1'b0;
        end else begin
            irq_d_q     <= irq_d_d;
            mask_q      <= mask_d;
            pend_q      <= pend_d;
            cause_vld_q <= cause_vld_d;
            cause_id_q  <= cause_id_d;
            state_q     <= state_d;
            intr_q      <= intr_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (bus.Sel) begin
            case (reg_off)
                INTC_MASK:  rdata[NSRC-1:0] = mask_q;
                INTC_PEND:  rdata[NSRC-1:0] = pend_q;
                INTC_CAUSE: begin
                    rdata[CAUSE_VALID_BIT] = cause_vld_q;
                    rdata[3:0]             = cause_id_q;
                end
                default:    rdata = '0;
            endcase
        end
    end

    assign bus.Rdata = rdata;
    assign bus.Intr  = intr_q;

endmodule
